// File: rtl/rv32_ctrl_pkg.sv
// Shared types and constants for the RV32I fetch/decode sequencing logic.
// The decode-stage instruction mux uses NOP_INSTR when flush is asserted.
package rv32_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } flush_state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_TRAP   = 2'b10,
    PC_MEPC   = 2'b11
  } pc_sel_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_flush_ctrl_if.sv
// Fetch/decode boundary control signals between the pipeline and the flush controller.
// The master is the pipeline side; the slave is the controller.
interface pipeline_flush_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid_in;
  logic             redirect_in;
  logic             mret_in;
  logic             trap_req_in;
  logic             load_use_in;
  logic             flush_out;
  logic             stall_out;
  logic [1:0]       pc_sel_out;
  logic             trap_ack_out;
  logic [CNT_W-1:0] flush_events_out;

  modport master (
    output instr_valid_in, redirect_in, mret_in, trap_req_in, load_use_in,
    input  flush_out, stall_out, pc_sel_out, trap_ack_out, flush_events_out
  );

  modport slave (
    input  instr_valid_in, redirect_in, mret_in, trap_req_in, load_use_in,
    output flush_out, stall_out, pc_sel_out, trap_ack_out, flush_events_out
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that holds at its maximum value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_flush_ctrl.sv
// Fetch/decode sequencing: NOP injection, PC/IF-ID hold and next-PC select
// for redirects, mret, trap entry with drain, load-use stalls and post-reset bubble.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal issue; redirects, traps and load-use evaluated here
// ST_FLUSH | discard cnt valid fetched words, decode sees NOP
// ST_TRAP  | older instructions drain for cnt cycles, then trap vector
module pipeline_flush_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  pipeline_flush_ctrl_if.slave bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES);

  flush_state_t state, state_nxt;
  logic [2:0]   cnt, cnt_nxt;
  pc_sel_t      pc_sel;
  logic         stall;
  logic         trap_ack;
  logic         flush_inc;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= ST_FLUSH;
      cnt   <= FLUSH_LOAD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_sel    = PC_PLUS4;
    stall     = 1'b0;
    trap_ack  = 1'b0;
    flush_inc = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (bus.mret_in) begin
          pc_sel    = PC_MEPC;
          state_nxt = ST_FLUSH;
          cnt_nxt   = FLUSH_LOAD;
          flush_inc = 1'b1;
        end else if (bus.redirect_in) begin
          // a simultaneous trap request stays pending; it is level-held
          pc_sel    = PC_BRANCH;
          state_nxt = ST_FLUSH;
          cnt_nxt   = FLUSH_LOAD;
          flush_inc = 1'b1;
        end else if (bus.trap_req_in) begin
          stall     = 1'b1;
          state_nxt = ST_TRAP;
          cnt_nxt   = DRAIN_LOAD;
        end else if (bus.load_use_in) begin
          stall = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (bus.mret_in || bus.redirect_in) begin
          pc_sel    = bus.mret_in ? PC_MEPC : PC_BRANCH;
          cnt_nxt   = FLUSH_LOAD;
          flush_inc = 1'b1;
        end else if (bus.instr_valid_in) begin
          // only real discarded fetches consume a flush slot
          if (cnt == 3'd1) state_nxt = ST_RUN;
          else             cnt_nxt   = cnt - 3'd1;
        end
      end
      ST_TRAP: begin
        if (cnt == 3'd1) begin
          pc_sel    = PC_TRAP;
          trap_ack  = 1'b1;
          state_nxt = ST_FLUSH;
          cnt_nxt   = FLUSH_LOAD;
          flush_inc = 1'b1;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: begin
        state_nxt = ST_FLUSH;
        cnt_nxt   = FLUSH_LOAD;
      end
    endcase
  end

  assign bus.flush_out    = (state != ST_RUN);
  assign bus.stall_out    = stall;
  assign bus.pc_sel_out   = pc_sel;
  assign bus.trap_ack_out = trap_ack;

  sat_counter #(.W(CNT_W)) u_flush_events (
    .clk   (clk_in),
    .rst_n (rst_in),
    .inc   (flush_inc),
    .clr   (1'b0),
    .count (bus.flush_events_out)
  );

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// Scoreboard bench for pipeline_flush_ctrl with FLUSH_CYCLES=2, DRAIN_CYCLES=2, CNT_W=4.
module tb_pipeline_flush_ctrl;

  localparam int FC = 2;
  localparam int DC = 2;
  localparam int CW = 4;

  typedef struct {
    logic          flush;
    logic          stall;
    logic [1:0]    pc_sel;
    logic          ack;
    logic [CW-1:0] events;
    string         name;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  pipeline_flush_ctrl_if #(.CNT_W(CW)) pif ();

  pipeline_flush_ctrl #(
    .FLUSH_CYCLES (FC),
    .DRAIN_CYCLES (DC),
    .CNT_W        (CW)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (pif.slave)
  );

  always #5 clk = ~clk;

  // monitor: every cycle the controller presents a full output vector
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (pif.flush_out !== e.flush || pif.stall_out !== e.stall ||
          pif.pc_sel_out !== e.pc_sel || pif.trap_ack_out !== e.ack ||
          pif.flush_events_out !== e.events) begin
        n_fail++;
        $display("FAIL %s: got flush=%b stall=%b pc_sel=%b ack=%b events=%0d, want flush=%b stall=%b pc_sel=%b ack=%b events=%0d",
                 e.name, pif.flush_out, pif.stall_out, pif.pc_sel_out, pif.trap_ack_out,
                 pif.flush_events_out, e.flush, e.stall, e.pc_sel, e.ack, e.events);
      end
    end
  end

  // stim = {rst, valid, redirect, mret, trap, load_use}
  task automatic cyc(input logic [5:0] stim, input logic f, input logic s,
                     input logic [1:0] pc, input logic a, input int ev, input string nm);
    exp_t e;
    {rst, pif.instr_valid_in, pif.redirect_in, pif.mret_in, pif.trap_req_in, pif.load_use_in} = stim;
    e.flush  = f;
    e.stall  = s;
    e.pc_sel = pc;
    e.ack    = a;
    e.events = CW'(ev);
    e.name   = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] RST_V   = 6'b010000;
  localparam logic [5:0] IDLE    = 6'b110000;
  localparam logic [5:0] NOVALID = 6'b100000;
  localparam logic [5:0] REDIR   = 6'b111000;
  localparam logic [5:0] MRET_RD = 6'b111100;
  localparam logic [5:0] TRAP    = 6'b110010;
  localparam logic [5:0] RD_TRAP = 6'b111010;
  localparam logic [5:0] LU      = 6'b110001;
  localparam logic [5:0] RST_TRP = 6'b010010;

  initial begin
    int ev;
    {rst, pif.instr_valid_in, pif.redirect_in, pif.mret_in, pif.trap_req_in, pif.load_use_in} = RST_V;
    @(posedge clk);
    #1;
    cyc(RST_V,   1, 0, 2'b00, 0, 0, "reset_hold");
    cyc(IDLE,    1, 0, 2'b00, 0, 0, "reset_release_nop1");
    cyc(IDLE,    1, 0, 2'b00, 0, 0, "reset_release_nop2");
    cyc(IDLE,    0, 0, 2'b00, 0, 0, "reset_release_run");

    cyc(REDIR,   0, 0, 2'b01, 0, 0, "redirect_pcsel");
    cyc(IDLE,    1, 0, 2'b00, 0, 1, "redirect_flush1");
    cyc(NOVALID, 1, 0, 2'b00, 0, 1, "redirect_flush_invalid");
    cyc(IDLE,    1, 0, 2'b00, 0, 1, "redirect_flush2");
    cyc(IDLE,    0, 0, 2'b00, 0, 1, "redirect_back_to_run");

    cyc(LU,      0, 1, 2'b00, 0, 1, "load_use_1");
    cyc(LU,      0, 1, 2'b00, 0, 1, "load_use_2");
    cyc(IDLE,    0, 0, 2'b00, 0, 1, "load_use_release");

    cyc(RD_TRAP, 0, 0, 2'b01, 0, 1, "trap_redirect_wins");
    cyc(TRAP,    1, 0, 2'b00, 0, 2, "trap_deferred_flush1");
    cyc(TRAP,    1, 0, 2'b00, 0, 2, "trap_deferred_flush2");
    cyc(TRAP,    0, 1, 2'b00, 0, 2, "trap_entry_stall");
    cyc(TRAP,    1, 1, 2'b00, 0, 2, "trap_drain");
    cyc(TRAP,    1, 0, 2'b10, 1, 2, "trap_ack_vector");
    cyc(IDLE,    1, 0, 2'b00, 0, 3, "trap_flush1");
    cyc(IDLE,    1, 0, 2'b00, 0, 3, "trap_flush2");
    cyc(IDLE,    0, 0, 2'b00, 0, 3, "trap_back_to_run");

    cyc(REDIR,   0, 0, 2'b01, 0, 3, "b2b_first");
    cyc(IDLE,    1, 0, 2'b00, 0, 4, "b2b_flush1");
    cyc(REDIR,   1, 0, 2'b01, 0, 4, "b2b_reload");
    cyc(IDLE,    1, 0, 2'b00, 0, 5, "b2b_ext_flush1");
    cyc(IDLE,    1, 0, 2'b00, 0, 5, "b2b_ext_flush2");
    cyc(MRET_RD, 0, 0, 2'b11, 0, 5, "mret_beats_redirect");
    cyc(IDLE,    1, 0, 2'b00, 0, 6, "mret_flush1");
    cyc(IDLE,    1, 0, 2'b00, 0, 6, "mret_flush2");
    cyc(IDLE,    0, 0, 2'b00, 0, 6, "mret_back_to_run");

    ev = 6;
    for (int i = 0; i < 17; i++) begin
      cyc(REDIR, 0, 0, 2'b01, 0, ev, "sat_redirect");
      ev = (ev < 15) ? ev + 1 : 15;
      cyc(IDLE,  1, 0, 2'b00, 0, ev, "sat_flush1");
      cyc(IDLE,  1, 0, 2'b00, 0, ev, "sat_flush2");
    end
    cyc(IDLE,    0, 0, 2'b00, 0, 15, "sat_hold_15");

    cyc(TRAP,    0, 1, 2'b00, 0, 15, "rst_trap_entry");
    cyc(TRAP,    1, 1, 2'b00, 0, 15, "rst_trap_drain");
    cyc(RST_TRP, 1, 0, 2'b00, 0, 0,  "rst_mid_trap");
    cyc(TRAP,    1, 0, 2'b00, 0, 0,  "rst_post_flush1");
    cyc(TRAP,    1, 0, 2'b00, 0, 0,  "rst_post_flush2");
    cyc(TRAP,    0, 1, 2'b00, 0, 0,  "rst_trap_retaken");
    cyc(TRAP,    1, 1, 2'b00, 0, 0,  "rst_retaken_drain");
    cyc(TRAP,    1, 0, 2'b10, 1, 0,  "rst_retaken_ack");
    cyc(IDLE,    1, 0, 2'b00, 0, 1,  "rst_retaken_flush1");

    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, want test completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
